// File: rtl/axi_mem_responder.sv
// AXI4 slave endpoint that serves one transaction at a time out of an on-chip
// 64-bit synchronous RAM window. It supports FIXED, INCR and WRAP bursts.
module axi_mem_responder #(
  parameter int unsigned       ADDR_W     = 36,
  parameter int unsigned       ID_W       = 1,
  parameter int unsigned       DEPTH_LOG2 = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 36'h0_4000_0000
) (
  input  logic              clk,
  input  logic              rst,
  // write address
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awlock,
  input  logic [3:0]        s_axi_awcache,
  input  logic [2:0]        s_axi_awprot,
  input  logic [3:0]        s_axi_awqos,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  // write data
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  // write response
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  // read address
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arlock,
  input  logic [3:0]        s_axi_arcache,
  input  logic [2:0]        s_axi_arprot,
  input  logic [3:0]        s_axi_arqos,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  // read data
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned HI_LSB = DEPTH_LOG2 + 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_e;

  state_e            state_q, state_d;
  logic              prio_wr_q, prio_wr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic              illegal_q, illegal_d;
  logic [7:0]        beat_q, beat_d;
  logic              over_q, over_d;
  logic              slv_q, slv_d;
  logic              dec_q, dec_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rhit_q, rhit_d;

  logic [63:0]       mem [DEPTH];
  logic [63:0]       ram_q;

  logic              aw_grant, ar_grant;
  logic              w_hs, r_hs, b_hs;
  logic              addr_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DEPTH_LOG2-1:0] ram_idx;

  logic [ID_W-1:0]   c_id;
  logic [ADDR_W-1:0] c_addr;
  logic [7:0]        c_len;
  logic [2:0]        c_size;
  logic [1:0]        c_burst;
  logic              c_illegal;

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        burst,
                                                  input logic [2:0]        size,
                                                  input logic [7:0]        len);
    logic [ADDR_W-1:0] step, inc, mask;
    step = ADDR_W'(1) << size;
    inc  = a + step;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      BURST_FIXED: next_addr = a;
      BURST_WRAP:  next_addr = (a & ~mask) | (inc & mask);
      default:     next_addr = inc;
    endcase
  endfunction

  // Grants are only offered in IDLE and never while reset is asserted.
  assign aw_grant = (state_q == S_IDLE) & ~rst & s_axi_awvalid & (~s_axi_arvalid | prio_wr_q);
  assign ar_grant = (state_q == S_IDLE) & ~rst & s_axi_arvalid & (~s_axi_awvalid | ~prio_wr_q);

  assign w_hs = (state_q == S_WDATA) & s_axi_wvalid;
  assign r_hs = (state_q == S_RDATA) & s_axi_rready;
  assign b_hs = (state_q == S_WRESP) & s_axi_bready;

  assign addr_hit = (addr_q[ADDR_W-1:HI_LSB] == BASE_ADDR[ADDR_W-1:HI_LSB]);
  assign ram_idx  = addr_q[HI_LSB-1:3];
  assign addr_nxt = next_addr(addr_q, burst_q, size_q, len_q);
  assign mem_we   = w_hs & ~over_q & addr_hit & ~illegal_q;

  assign s_axi_awready = aw_grant;
  assign s_axi_arready = ar_grant;
  assign s_axi_wready  = (state_q == S_WDATA);
  assign s_axi_bvalid  = (state_q == S_WRESP);
  assign s_axi_bid     = s_axi_bvalid ? id_q : '0;
  assign s_axi_bresp   = !s_axi_bvalid ? RESP_OKAY :
                         dec_q         ? RESP_DECERR :
                         slv_q         ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rvalid  = (state_q == S_RDATA);
  assign s_axi_rid     = s_axi_rvalid ? id_q : '0;
  assign s_axi_rresp   = s_axi_rvalid ? rresp_q : RESP_OKAY;
  assign s_axi_rlast   = s_axi_rvalid & rlast_q;
  assign s_axi_rdata   = (s_axi_rvalid & rhit_q) ? ram_q : '0;

  // Next-state logic: request capture, beat bookkeeping and error accumulation.
  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    illegal_d = illegal_q;
    beat_d    = beat_q;
    over_d    = over_q;
    slv_d     = slv_q;
    dec_d     = dec_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rhit_d    = rhit_q;

    if (aw_grant) begin
      c_id    = s_axi_awid;
      c_addr  = s_axi_awaddr;
      c_len   = s_axi_awlen;
      c_size  = s_axi_awsize;
      c_burst = s_axi_awburst;
    end else begin
      c_id    = s_axi_arid;
      c_addr  = s_axi_araddr;
      c_len   = s_axi_arlen;
      c_size  = s_axi_arsize;
      c_burst = s_axi_arburst;
    end
    c_illegal = (c_burst == 2'b11) || (c_size > 3'd3) ||
                ((c_burst == BURST_WRAP) &&
                 !(c_len == 8'd1 || c_len == 8'd3 || c_len == 8'd7 || c_len == 8'd15));

    case (state_q)
      S_IDLE: begin
        if (aw_grant || ar_grant) begin
          id_d      = c_id;
          addr_d    = c_addr;
          len_d     = c_len;
          size_d    = c_illegal ? 3'd3 : c_size;
          burst_d   = c_illegal ? BURST_INCR : c_burst;
          illegal_d = c_illegal;
          beat_d    = '0;
          over_d    = 1'b0;
          slv_d     = c_illegal;
          dec_d     = 1'b0;
          prio_wr_d = ar_grant;
          state_d   = aw_grant ? S_WDATA : S_RADDR;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          addr_d = addr_nxt;
          // Once len+1 beats have been taken, further beats are dropped as overruns.
          if (over_q) begin
            slv_d = 1'b1;
          end else begin
            if (!addr_hit) dec_d = 1'b1;
            if (s_axi_wlast && (beat_q != len_q)) slv_d = 1'b1;
            if (beat_q == len_q) over_d = 1'b1;
            else                 beat_d = beat_q + 8'd1;
          end
          if (s_axi_wlast) state_d = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_hs) state_d = S_IDLE;
      end
      S_RADDR: begin
        rresp_d = !addr_hit ? RESP_DECERR : (illegal_q ? RESP_SLVERR : RESP_OKAY);
        rlast_d = (beat_q == len_q);
        rhit_d  = addr_hit;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        if (r_hs) begin
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = addr_nxt;
            state_d = S_RADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and transaction registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prio_wr_q <= 1'b1;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      illegal_q <= 1'b0;
      beat_q    <= '0;
      over_q    <= 1'b0;
      slv_q     <= 1'b0;
      dec_q     <= 1'b0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rhit_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      illegal_q <= illegal_d;
      beat_q    <= beat_d;
      over_q    <= over_d;
      slv_q     <= slv_d;
      dec_q     <= dec_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rhit_q    <= rhit_d;
    end
  end

  // RAM: byte-masked write, registered read issued only from RADDR so the
  // read word stays stable while a beat is stalled.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem[ram_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
    if (state_q == S_RADDR) ram_q <= mem[ram_idx];
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed scoreboard bench for axi_mem_responder.
module tb_axi_mem_responder;
  localparam int unsigned ADDR_W = 36;
  localparam int unsigned ID_W   = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen, wstrb;
  logic [2:0]        awsize, arsize, awprot, arprot;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awlock, arlock;
  logic [3:0]        awcache, arcache, awqos, arqos;
  logic              awvalid, awready, wvalid, wready, wlast;
  logic              bvalid, bready, arvalid, arready, rvalid, rready, rlast;
  logic [63:0]       wdata, rdata;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } rbeat_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bresp_t;

  rbeat_t exp_r[$];
  bresp_t exp_b[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_mem_responder #(
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .DEPTH_LOG2(14),
    .BASE_ADDR (36'h0_4000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
    .s_axi_awprot(awprot), .s_axi_awqos(awqos), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
    .s_axi_arprot(arprot), .s_axi_arqos(arqos), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_r(input logic [ID_W-1:0] id, input logic [63:0] data,
                        input logic [1:0] resp, input logic last);
    rbeat_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic push_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
    bresp_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  // Compare the beat currently on the R channel with the scoreboard head.
  task automatic r_compare();
    rbeat_t e;
    if (exp_r.size() == 0) begin
      checks++; failures++;
      $error("FAIL r_underflow observed=unexpected-beat expected=no-beat");
    end else begin
      e = exp_r.pop_front();
      chk("rid",   rid,   e.id);
      chk("rdata", rdata, e.data);
      chk("rresp", rresp, e.resp);
      chk("rlast", rlast, e.last);
    end
  endtask

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [35:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [35:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst;
    arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (arready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  // Write beats are accepted every cycle, starting the cycle after AW.
  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("w_rate", n, 0);
    @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_recv();
    int n;
    bresp_t e;
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("b_latency", n, 0);
    if (exp_b.size() == 0) begin
      checks++; failures++;
      $error("FAIL b_underflow observed=unexpected-response expected=no-response");
    end else begin
      e = exp_b.pop_front();
      chk("bid",   bid,   e.id);
      chk("bresp", bresp, e.resp);
    end
    @(posedge clk); #1 bready = 1'b0;
  endtask

  // With rready held high each beat appears exactly two cycles after the
  // preceding AR or R handshake.
  task automatic r_recv(input int beats);
    int n;
    rready = 1'b1;
    for (int i = 0; i < beats; i++) begin
      n = 1;
      @(negedge clk);
      while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("r_cadence", n, 2);
      r_compare();
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b1;
    awlock = 1'b0; awcache = '0; awprot = '0; awqos = '0;
    arlock = 1'b0; arcache = '0; arprot = '0; arqos = '0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;

    // Reset state, with requests pending so the grant gating is exercised.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready",  wready,  0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_rvalid",  rvalid,  0);
    chk("rst_bresp",   bresp,   0);
    chk("rst_rdata",   rdata,   0);
    chk("rst_rlast",   rlast,   0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // INCR write of four words, then read them back.
    aw_send(1'b0, 36'h0_4000_0000, 8'd3, 2'b01);
    w_send(64'h11, 8'hFF, 1'b0);
    w_send(64'h22, 8'hFF, 1'b0);
    w_send(64'h33, 8'hFF, 1'b0);
    w_send(64'h44, 8'hFF, 1'b1);
    push_b(1'b0, 2'b00);
    b_recv();
    ar_send(1'b0, 36'h0_4000_0000, 8'd3, 2'b01);
    push_r(1'b0, 64'h11, 2'b00, 1'b0);
    push_r(1'b0, 64'h22, 2'b00, 1'b0);
    push_r(1'b0, 64'h33, 2'b00, 1'b0);
    push_r(1'b0, 64'h44, 2'b00, 1'b1);
    r_recv(4);

    // WRAP read starting mid-block: 0x18, 0x00, 0x08, 0x10.
    ar_send(1'b1, 36'h0_4000_0018, 8'd3, 2'b10);
    push_r(1'b1, 64'h44, 2'b00, 1'b0);
    push_r(1'b1, 64'h11, 2'b00, 1'b0);
    push_r(1'b1, 64'h22, 2'b00, 1'b0);
    push_r(1'b1, 64'h33, 2'b00, 1'b1);
    r_recv(4);

    // Illegal WRAP length: runs as INCR, every beat SLVERR.
    ar_send(1'b0, 36'h0_4000_0000, 8'd2, 2'b10);
    push_r(1'b0, 64'h11, 2'b10, 1'b0);
    push_r(1'b0, 64'h22, 2'b10, 1'b0);
    push_r(1'b0, 64'h33, 2'b10, 1'b1);
    r_recv(3);

    // Partial strobe over a word of all ones.
    aw_send(1'b0, 36'h0_4000_0008, 8'd0, 2'b01);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    push_b(1'b0, 2'b00);
    b_recv();
    aw_send(1'b0, 36'h0_4000_0008, 8'd0, 2'b01);
    w_send(64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 1'b1);
    push_b(1'b0, 2'b00);
    b_recv();
    ar_send(1'b0, 36'h0_4000_0008, 8'd0, 2'b01);
    push_r(1'b0, 64'hFFFF_FFFF_CCCC_DDDD, 2'b00, 1'b1);
    r_recv(1);

    // Out-of-window write is dropped with DECERR; aliased word unchanged.
    aw_send(1'b1, 36'h0_0000_0000, 8'd0, 2'b01);
    w_send(64'hDEAD_BEEF, 8'hFF, 1'b1);
    push_b(1'b1, 2'b11);
    b_recv();
    ar_send(1'b0, 36'h0_4000_0000, 8'd0, 2'b01);
    push_r(1'b0, 64'h11, 2'b00, 1'b1);
    r_recv(1);
    ar_send(1'b1, 36'h0_0000_0000, 8'd0, 2'b01);
    push_r(1'b1, 64'h0, 2'b11, 1'b1);
    r_recv(1);

    // Simultaneous requests from reset alternate write, read, write.
    rst = 1'b1;
    @(posedge clk); #1;
    awid = 1'b0; awaddr = 36'h0_4000_0020; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01;
    arid = 1'b1; araddr = 36'h0_4000_0020; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01;
    awvalid = 1'b1; arvalid = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("arb1_awready", awready, 1);
    chk("arb1_arready", arready, 0);
    @(posedge clk); #1;
    chk("busy_awready", awready, 0);
    chk("busy_arready", arready, 0);
    w_send(64'h5555, 8'hFF, 1'b1);
    push_b(1'b0, 2'b00);
    b_recv();
    chk("arb2_awready", awready, 0);
    chk("arb2_arready", arready, 1);
    @(posedge clk); #1;
    chk("rbusy_awready", awready, 0);
    push_r(1'b1, 64'h5555, 2'b00, 1'b1);
    r_recv(1);
    chk("arb3_awready", awready, 1);
    chk("arb3_arready", arready, 0);
    @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
    w_send(64'h6666, 8'hFF, 1'b1);
    push_b(1'b0, 2'b00);
    b_recv();

    // Early wlast, then an overrun beat beyond len+1.
    aw_send(1'b0, 36'h0_4000_0040, 8'd3, 2'b01);
    w_send(64'hA1, 8'hFF, 1'b0);
    w_send(64'hA2, 8'hFF, 1'b1);
    push_b(1'b0, 2'b10);
    b_recv();
    aw_send(1'b1, 36'h0_4000_0048, 8'd0, 2'b01);
    w_send(64'hB1, 8'hFF, 1'b0);
    w_send(64'hB2, 8'hFF, 1'b1);
    push_b(1'b1, 2'b10);
    b_recv();

    // Read stalled by rready low for five cycles, then reset mid-burst.
    ar_send(1'b0, 36'h0_4000_0000, 8'd1, 2'b01);
    begin
      int n;
      n = 1;
      @(negedge clk);
      while (rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("stall_first", n, 2);
      for (int k = 0; k < 5; k++) begin
        chk("stall_rvalid", rvalid, 1);
        chk("stall_rdata",  rdata,  64'h11);
        chk("stall_rlast",  rlast,  0);
        @(negedge clk);
      end
      push_r(1'b0, 64'h11, 2'b00, 1'b0);
      rready = 1'b1;
      r_compare();
      @(posedge clk); #1 rready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("beat1_rvalid", rvalid, 1);
      rst = 1'b1;
      #1;
      chk("abort_rvalid", rvalid, 0);
      chk("abort_rdata",  rdata,  0);
      chk("abort_rlast",  rlast,  0);
      chk("abort_arready", arready, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rready = 1'b1; bready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("post_abort_rvalid", rvalid, 0);
        chk("post_abort_bvalid", bvalid, 0);
      end
      @(posedge clk); #1 rready = 1'b0; bready = 1'b0;
    end

    // RAM contents survive reset.
    ar_send(1'b1, 36'h0_4000_0020, 8'd0, 2'b01);
    push_r(1'b1, 64'h6666, 2'b00, 1'b1);
    r_recv(1);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
